// File: rtl/mac_tx_arb.sv
// mac_tx_arb: frame-granular round-robin arbiter sharing the MAC TX datapath
//   between source 0 (IPv4) and source 1 (control/ARP).
// Latency: request-to-grant 1 cycle; forward beat path is combinational (0 cycles).
// Backpressure: ready_i is passed to the granted source only; FLUSH drains the
//   granted source at full rate; GAP holds both sources off for IPG_CYC cycles.
// Ports:
//   clk, nreset              clock, async active-low reset
//   req_i/valid_i/data_i/keep_i/last_i  per-source frame request and beat stream
//   ready_o                  per-source beat accept
//   valid_o/data_o/keep_o/last_o, ready_i  beat stream to the MAC
//   cancel_i                 MAC aborts the frame in flight
//   grant_o, abort_o, busy_o one-hot grant, drained-cancel pulse, not-idle
module mac_tx_arb #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int IPG_N  = 12
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [1:0]            req_i,
  input  logic [1:0]            valid_i,
  input  logic [2*DATA_W-1:0]   data_i,
  input  logic [2*KEEP_W-1:0]   keep_i,
  input  logic [1:0]            last_i,
  output logic [1:0]            ready_o,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [KEEP_W-1:0]     keep_o,
  output logic                  last_o,
  input  logic                  ready_i,
  input  logic                  cancel_i,
  output logic [1:0]            grant_o,
  output logic                  abort_o,
  output logic                  busy_o
);

  localparam int IPG_CYC = (IPG_N + KEEP_W - 1) / KEEP_W;
  localparam int GAP_W   = $clog2(IPG_CYC + 1);
  // Keep the counter at least one bit wide so IPG_CYC = 0 still elaborates.
  localparam int CNT_W   = (GAP_W < 1) ? 1 : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LOAD = (IPG_CYC > 0) ? CNT_W'(IPG_CYC - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_XFER  = 4'b0010,
    S_FLUSH = 4'b0100,
    S_GAP   = 4'b1000
  } state_t;

  // State after a frame ends: GAP, or straight to IDLE when there is no gap.
  localparam state_t S_END = (IPG_CYC == 0) ? S_IDLE : S_GAP;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;

  // Granted source index; grant_q is one-hot so bit 1 identifies it.
  logic              sel;
  logic              src_valid;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic [KEEP_W-1:0] src_keep;
  logic              pick;

  assign sel       = grant_q[1];
  assign src_valid = valid_i[sel];
  assign src_last  = last_i[sel];
  assign src_data  = sel ? data_i[DATA_W +: DATA_W] : data_i[0 +: DATA_W];
  assign src_keep  = sel ? keep_i[KEEP_W +: KEEP_W] : keep_i[0 +: KEEP_W];

  // On a tie the source not granted last time wins; otherwise the lone requester.
  assign pick = (req_i == 2'b11) ? ~last_q : req_i[1];

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    gap_d   = gap_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (src_valid && ready_i && src_last) begin
          // A cancel coinciding with the last handshake still completes the frame.
          state_d = S_END;
          grant_d = 2'b00;
          gap_d   = GAP_LOAD;
          abort_d = cancel_i;
        end else if (cancel_i) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (src_valid && src_last) begin
          state_d = S_END;
          grant_d = 2'b00;
          gap_d   = GAP_LOAD;
          abort_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Output logic: everything to the MAC is zero outside XFER.
  always_comb begin
    ready_o = 2'b00;
    valid_o = 1'b0;
    data_o  = '0;
    keep_o  = '0;
    last_o  = 1'b0;
    case (state_q)
      S_XFER: begin
        valid_o = src_valid;
        data_o  = src_data;
        keep_o  = src_last ? src_keep : '1;
        last_o  = src_last;
        ready_o = sel ? {ready_i, 1'b0} : {1'b0, ready_i};
      end
      S_FLUSH: begin
        ready_o = sel ? 2'b10 : 2'b01;
      end
      default: begin
        ready_o = 2'b00;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign abort_o = abort_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_tx_arb.sv
// tb_mac_tx_arb: randomized frames from both sources against a frame-level
//   arbitration model, plus directed cancel, reset and 64-bit gap cases.
module tb_mac_tx_arb;

  localparam int DW      = 16;
  localparam int KW      = 2;
  localparam int IPG_CYC = 6;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [1:0]    req_i = '0, valid_i = '0, last_i = '0;
  logic [2*DW-1:0] data_i = '0;
  logic [2*KW-1:0] keep_i = '0;
  logic [1:0]    ready_o;
  logic          valid_o, last_o;
  logic [DW-1:0] data_o;
  logic [KW-1:0] keep_o;
  logic          ready_i = 1'b0, cancel_i = 1'b0;
  logic [1:0]    grant_o;
  logic          abort_o, busy_o;

  // 64-bit instance for the short-gap case
  logic [1:0]    w_req_i = '0, w_valid_i = '0, w_last_i = '0;
  logic [127:0]  w_data_i = '0;
  logic [15:0]   w_keep_i = '0;
  logic [1:0]    w_ready_o;
  logic          w_valid_o, w_last_o;
  logic [63:0]   w_data_o;
  logic [7:0]    w_keep_o;
  logic          w_ready_i = 1'b1, w_cancel_i = 1'b0;
  logic [1:0]    w_grant_o;
  logic          w_abort_o, w_busy_o;

  always #5 clk = ~clk;

  mac_tx_arb #(.DATA_W(DW)) dut (
    .clk(clk), .nreset(nreset), .req_i(req_i), .valid_i(valid_i),
    .data_i(data_i), .keep_i(keep_i), .last_i(last_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .keep_o(keep_o), .last_o(last_o),
    .ready_i(ready_i), .cancel_i(cancel_i), .grant_o(grant_o),
    .abort_o(abort_o), .busy_o(busy_o)
  );

  mac_tx_arb #(.DATA_W(64), .IPG_N(12)) dut64 (
    .clk(clk), .nreset(nreset), .req_i(w_req_i), .valid_i(w_valid_i),
    .data_i(w_data_i), .keep_i(w_keep_i), .last_i(w_last_i), .ready_o(w_ready_o),
    .valid_o(w_valid_o), .data_o(w_data_o), .keep_o(w_keep_o), .last_o(w_last_o),
    .ready_i(w_ready_i), .cancel_i(w_cancel_i), .grant_o(w_grant_o),
    .abort_o(w_abort_o), .busy_o(w_busy_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Source stimulus state
  int          fr_left [2];
  int          bl [2];
  logic [15:0] cd [2];
  logic [1:0]  ck [2];

  // Frame-level model: owner of the datapath, last winner, first cycle a request may be seen
  int m_own, m_last, m_ok;

  logic [1:0]  eg, er, ek;
  logic        ev, el, eb;
  logic [15:0] ed;
  int          guard;
  int          k;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_outputs", 64'({grant_o, valid_o, ready_o, busy_o, abort_o, last_o, keep_o, data_o}), 64'd0);
    nreset = 1'b1;
    step();

    // ---------------- randomized frames from both sources ----------------
    fr_left[0] = 8; fr_left[1] = 8;
    bl[0] = 0; bl[1] = 0;
    m_own = -1; m_last = 1; m_ok = cyc;
    guard = 0;
    while ((fr_left[0] + fr_left[1] + bl[0] + bl[1]) > 0 && guard < 4000) begin
      guard++;
      for (int s = 0; s < 2; s++) begin
        if (bl[s] == 0 && fr_left[s] > 0) begin
          bl[s] = $urandom_range(1, 4);
          fr_left[s]--;
          cd[s] = 16'($urandom);
          ck[s] = 2'($urandom_range(1, 3));
        end
        req_i[s]   = (bl[s] > 0);
        valid_i[s] = (bl[s] > 0) && ($urandom_range(0, 3) != 0);
        last_i[s]  = (bl[s] == 1);
      end
      data_i  = {cd[1], cd[0]};
      keep_i  = {ck[1], ck[0]};
      ready_i = ($urandom_range(0, 2) != 0);

      smp();
      eg = 2'b00; ev = 1'b0; er = 2'b00; ed = '0; el = 1'b0; ek = 2'b00;
      if (m_own >= 0) begin
        eg = (m_own == 1) ? 2'b10 : 2'b01;
        ev = valid_i[m_own];
        er = (m_own == 1) ? {ready_i, 1'b0} : {1'b0, ready_i};
        ed = cd[m_own];
        el = (bl[m_own] == 1);
        ek = el ? ck[m_own] : 2'b11;
      end
      eb = (m_own >= 0) || (cyc < m_ok);
      chk("rand_cycle", 64'({grant_o, valid_o, ready_o, busy_o, abort_o, last_o, keep_o, data_o}),
          64'({eg, ev, er, eb, 1'b0, el, ek, ed}));

      // Model update at the coming edge
      if (m_own >= 0) begin
        if (valid_i[m_own] && ready_i && bl[m_own] == 1) begin
          m_own = -1;
          m_ok  = cyc + IPG_CYC + 1;
        end
      end else if (cyc >= m_ok && req_i != 2'b00) begin
        m_own  = (req_i == 2'b11) ? (1 - m_last) : (req_i[1] ? 1 : 0);
        m_last = m_own;
      end
      // Sources advance on their own handshakes
      for (int s = 0; s < 2; s++) begin
        if (valid_i[s] && ready_o[s]) begin
          bl[s]--;
          cd[s] = 16'($urandom);
          ck[s] = 2'($urandom_range(1, 3));
        end
      end
      step();
    end
    chk("rand_done", 64'(fr_left[0] + fr_left[1] + bl[0] + bl[1]), 64'd0);
    req_i = '0; valid_i = '0; last_i = '0; ready_i = 1'b0;
    for (int i = 0; i < IPG_CYC + 2; i++) step();

    // ---------------- cancel mid-frame, source 1 ----------------
    req_i = 2'b10; ready_i = 1'b1;
    step();
    valid_i = 2'b10; data_i = {16'hC001, 16'h0}; keep_i = {2'b01, 2'b00}; last_i = 2'b00;
    smp(); chk("c_grant", 64'(grant_o), 64'(2'b10));
    step();
    data_i = {16'hC002, 16'h0}; cancel_i = 1'b1;
    smp(); chk("c_beat2", 64'({valid_o, data_o}), 64'({1'b1, 16'hC002}));
    step();
    cancel_i = 1'b0; ready_i = 1'b0; data_i = {16'hC003, 16'h0};
    smp(); chk("c_flush3", 64'({valid_o, ready_o, data_o, abort_o, busy_o}), 64'({1'b0, 2'b10, 16'h0, 1'b0, 1'b1}));
    step();
    data_i = {16'hC004, 16'h0};
    smp(); chk("c_flush4", 64'({valid_o, ready_o, data_o, abort_o, busy_o}), 64'({1'b0, 2'b10, 16'h0, 1'b0, 1'b1}));
    step();
    data_i = {16'hC005, 16'h0}; last_i = 2'b10;
    smp(); chk("c_flush_last", 64'({valid_o, ready_o, abort_o, last_o}), 64'({1'b0, 2'b10, 1'b0, 1'b0}));
    step();
    req_i = '0; valid_i = '0; last_i = '0;
    smp(); chk("c_abort", 64'({abort_o, grant_o, busy_o, ready_o}), 64'({1'b1, 2'b00, 1'b1, 2'b00}));
    step();
    smp(); chk("c_abort_once", 64'({abort_o, busy_o}), 64'({1'b0, 1'b1}));
    for (int i = 0; i < IPG_CYC; i++) step();

    // ---------------- cancel on the last handshake, source 0 ----------------
    req_i = 2'b01; ready_i = 1'b1;
    step();
    valid_i = 2'b01; data_i = {16'h0, 16'hA001}; keep_i = {2'b00, 2'b01}; last_i = 2'b00;
    smp(); chk("d_grant", 64'({grant_o, keep_o}), 64'({2'b01, 2'b11}));
    step();
    data_i = {16'h0, 16'hA002}; last_i = 2'b01; cancel_i = 1'b1;
    smp(); chk("d_last", 64'({valid_o, last_o, keep_o, data_o}), 64'({1'b1, 1'b1, 2'b01, 16'hA002}));
    step();
    cancel_i = 1'b0; valid_i = '0; last_i = '0; req_i = '0;
    smp(); chk("d_abort", 64'({abort_o, grant_o, busy_o, ready_o, valid_o}), 64'({1'b1, 2'b00, 1'b1, 2'b00, 1'b0}));
    step();
    smp(); chk("d_abort_once", 64'({abort_o, busy_o}), 64'({1'b0, 1'b1}));
    for (int i = 0; i < IPG_CYC; i++) step();

    // ---------------- async reset mid-frame, source 0 ----------------
    req_i = 2'b01; ready_i = 1'b1;
    step();
    valid_i = 2'b01; last_i = 2'b00; data_i = {16'h0, 16'hB001};
    step();
    data_i = {16'h0, 16'hB002};
    step();
    data_i = {16'h0, 16'hB003};
    #1;
    chk("e_pre_rst", 64'({valid_o, grant_o, busy_o}), 64'({1'b1, 2'b01, 1'b1}));
    nreset = 1'b0;
    #1;
    chk("e_async_rst", 64'({valid_o, grant_o, ready_o, busy_o}), 64'd0);
    #1;
    nreset = 1'b1;
    req_i = 2'b11; valid_i = '0;
    step();
    smp(); chk("e_tie_after_rst", 64'(grant_o), 64'(2'b01));
    valid_i = 2'b01; last_i = 2'b01;
    step();
    req_i = '0; valid_i = '0; last_i = '0;
    for (int i = 0; i < IPG_CYC + 2; i++) step();

    // ---------------- 64-bit datapath: two-cycle gap ----------------
    w_req_i = 2'b01; w_valid_i = 2'b01; w_last_i = 2'b01;
    w_keep_i = {8'h00, 8'h0F}; w_data_i = {64'h0, 64'h1122334455667788};
    step();
    smp(); chk("f_first_last", 64'({w_valid_o, w_last_o, w_keep_o}), 64'({1'b1, 1'b1, 8'h0F}));
    step();
    w_req_i = 2'b10; w_valid_i = 2'b10; w_last_i = 2'b10;
    w_data_i = {64'h99AABBCCDDEEFF00, 64'h0};
    for (k = 1; k <= 20; k++) begin
      smp();
      if (w_valid_o) break;
      step();
    end
    chk("f_gap64", 64'(k), 64'd4);
    chk("f_grant64", 64'({w_grant_o, w_data_o}), {2'b10, 64'h99AABBCCDDEEFF00} & 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    w_req_i = '0; w_valid_i = '0; w_last_i = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
